// File: rtl/mult_div.sv
// mult_div: sequential multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   start, op, a, b    operation request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   hi_we, lo_we,      direct HI/LO writes (MTHI/MTLO), honoured only when
//   wdata              idle and not starting an operation
//   busy               iteration in progress
//   done               one-cycle result-ready pulse
//   div_by_zero        one-cycle pulse alongside done for a zero divisor
//   hi, lo             architectural HI/LO registers
module mult_div #(
    parameter int unsigned width = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [width-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [width-1:0] hi,
    output logic [width-1:0] lo
);

    localparam int unsigned CW = $clog2(width + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*width-1:0] acc_q;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [width-1:0]   b_q;        // multiplicand / divisor magnitude
    logic               is_div_q;
    logic               neg_res_q;  // product / quotient must be negated
    logic               neg_rem_q;  // remainder must be negated
    logic               dbz_pend_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [width-1:0]   hi_q;
    logic [width-1:0]   lo_q;

    // Operand magnitudes: signed ops iterate on absolute values
    logic             sgn_op;
    logic [width-1:0] a_mag;
    logic [width-1:0] b_mag;

    always_comb begin
        sgn_op = ~op[0];
        a_mag  = (sgn_op && a[width-1]) ? -a : a;
        b_mag  = (sgn_op && b[width-1]) ? -b : b;
    end

    // One iteration of the datapath, plus sign-corrected final result
    logic [width:0]     mul_sum;
    logic [2*width-1:0] mul_next;
    logic [width:0]     div_shift;
    logic [width:0]     div_diff;
    logic               div_ge;
    logic [2*width-1:0] div_next;
    logic [2*width-1:0] step;
    logic [width-1:0]   res_hi;
    logic [width-1:0]   res_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*width-1:width]} + (acc_q[0] ? {1'b0, b_q} : {(width+1){1'b0}});
        mul_next  = {mul_sum, acc_q[width-1:1]};
        div_shift = {acc_q[2*width-1:width], acc_q[width-1]};
        div_diff  = div_shift - {1'b0, b_q};
        // Borrow out of the trial subtraction means the divisor did not fit
        div_ge    = ~div_diff[width];
        div_next  = {(div_ge ? div_diff[width-1:0] : div_shift[width-1:0]),
                     acc_q[width-2:0], div_ge};
        step      = is_div_q ? div_next : mul_next;
        if (is_div_q) begin
            res_lo = neg_res_q ? -step[width-1:0] : step[width-1:0];
            res_hi = neg_rem_q ? -step[2*width-1:width] : step[2*width-1:width];
        end else begin
            {res_hi, res_lo} = neg_res_q ? -step : step;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q      <= {{width{1'b0}}, a_mag};
                        b_q        <= b_mag;
                        is_div_q   <= op[1];
                        neg_res_q  <= sgn_op & (a[width-1] ^ b[width-1]);
                        neg_rem_q  <= sgn_op & a[width-1];
                        cnt_q      <= CW'(width);
                        if (op[1] && (b == '0)) begin
                            dbz_pend_q <= 1'b1;
                            state_q    <= FINISH;
                        end else begin
                            dbz_pend_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= RUN;
                        end
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                // width-1 iterations here; the last one is folded into FINISH
                RUN: begin
                    acc_q <= step;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(2)) begin
                        busy_q  <= 1'b0;
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    done_q <= 1'b1;
                    if (dbz_pend_q) begin
                        dbz_q <= 1'b1;
                    end else begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                    dbz_pend_q <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: randomized and directed bench for mult_div with an
// arithmetic reference model compared against the DUT on every cycle.
module tb_mult_div;

    localparam int unsigned W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op    = 2'b00;
    logic [W-1:0]  a     = '0;
    logic [W-1:0]  b     = '0;
    logic          hi_we = 1'b0;
    logic          lo_we = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    mult_div #(.width(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model state: cycles until result, pending result, visible regs
    int            m_rem  = 0;
    logic [63:0]   m_pend = '0;
    bit            m_pdbz = 1'b0;
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic          m_dbz  = 1'b0;
    logic [31:0]   m_hi   = '0;
    logic [31:0]   m_lo   = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic result {hi, lo}; signed division truncates toward zero
    function automatic logic [63:0] calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, sq, sr;
        logic [63:0] ux, uy, r, qv, rv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            2'd0: r = 64'(sx * sy);
            2'd1: r = ux * uy;
            2'd2: begin
                sq = sx / sy;
                sr = sx % sy;
                qv = 64'(sq);
                rv = 64'(sr);
                r  = {rv[31:0], qv[31:0]};
            end
            default: r = {32'(x % y), 32'(x / y)};
        endcase
        return r;
    endfunction

    task automatic model_edge();
        m_done = 1'b0;
        m_dbz  = 1'b0;
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1'b1;
                if (m_pdbz) m_dbz = 1'b1;
                else {m_hi, m_lo} = m_pend;
            end
        end else if (start) begin
            m_pdbz = op[1] && (b == '0);
            if (!m_pdbz) m_pend = calc(op, a, b);
            m_rem = m_pdbz ? 1 : int'(W);
        end else begin
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
        end
        m_busy = (m_rem >= 2);
    endtask

    task automatic compare_all();
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
        chk("hi", 64'(hi), 64'(m_hi));
        chk("lo", 64'(lo), 64'(m_lo));
    endtask

    task automatic cyc(input bit st, input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input bit hw, input bit lw, input logic [31:0] wd);
        @(negedge clock);
        start = st; op = o; a = aa; b = bb; hi_we = hw; lo_we = lw; wdata = wd;
        @(posedge clock);
        model_edge();
        #1 compare_all();
    endtask

    // Idle cycles with operands scrambled to show they are not re-sampled
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 2'($urandom_range(3)), $urandom, $urandom, 1'b0, 1'b0, $urandom);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        #1;
        m_rem = 0; m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_hi = '0; m_lo = '0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        @(posedge clock);
        #1 compare_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(7))
            0: v = 32'h0;
            1: v = 32'h1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: v = 32'($urandom_range(15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        // Model pinned to hand-computed results
        chk("model_multu", calc(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("model_mult", calc(2'd0, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        chk("model_div", calc(2'd2, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("model_div_ovf", calc(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        chk("model_divu", calc(2'd3, 32'd100, 32'd7), 64'h0000_0002_0000_000E);

        #2 reset = 1'b1;
        #1;
        chk("por_busy", 64'(busy), 64'd0);
        chk("por_done", 64'(done), 64'd0);
        chk("por_dbz", 64'(div_by_zero), 64'd0);
        chk("por_hi", 64'(hi), 64'd0);
        chk("por_lo", 64'(lo), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // MULTU max*max with exact timing
        cyc(1'b1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        chk("multu_busy_start", 64'(busy), 64'd1);
        idle(31);
        chk("multu_busy_low_finish", 64'(busy), 64'd0);
        chk("multu_no_early_done", 64'(done), 64'd0);
        idle(1);
        chk("multu_done", 64'(done), 64'd1);
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0001);
        idle(1);
        chk("multu_done_one_cycle", 64'(done), 64'd0);

        // MULT -3*5, DIV -7/2
        cyc(1'b1, 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 32'h0);
        idle(33);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFF1);
        cyc(1'b1, 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'h0);
        idle(33);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);

        // MTHI/MTLO then DIVU by zero
        cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h11);
        cyc(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h22);
        cyc(1'b1, 2'd3, 32'd100, 32'd0, 1'b0, 1'b0, 32'h0);
        chk("dbz_not_busy", 64'(busy), 64'd0);
        idle(1);
        chk("dbz_done", 64'(done), 64'd1);
        chk("dbz_flag", 64'(div_by_zero), 64'd1);
        chk("dbz_hi", 64'(hi), 64'h11);
        chk("dbz_lo", 64'(lo), 64'h22);
        idle(1);
        chk("dbz_flag_one_cycle", 64'(div_by_zero), 64'd0);

        // DIV overflow and DIVU 100/7
        cyc(1'b1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        idle(32);
        chk("div_ovf_dbz", 64'(div_by_zero), 64'd0);
        chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(hi), 64'h0);
        idle(1);
        cyc(1'b1, 2'd3, 32'd100, 32'd7, 1'b0, 1'b0, 32'h0);
        idle(33);
        chk("divu_lo", 64'(lo), 64'd14);
        chk("divu_hi", 64'(hi), 64'd2);

        // Start and MTHI while busy are dropped
        cyc(1'b1, 2'd1, 32'd3, 32'd4, 1'b0, 1'b0, 32'h0);
        idle(4);
        cyc(1'b1, 2'd3, 32'd9, 32'd2, 1'b1, 1'b0, 32'hAA);
        idle(27);
        chk("ignore_done", 64'(done), 64'd1);
        chk("ignore_hi", 64'(hi), 64'h0);
        chk("ignore_lo", 64'(lo), 64'd12);
        idle(1);

        // Reset mid-operation, then a fresh MULTU
        cyc(1'b1, 2'd0, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0, 1'b0, 32'h0);
        idle(9);
        do_reset();
        cyc(1'b1, 2'd1, 32'd2, 32'd3, 1'b0, 1'b0, 32'h0);
        idle(32);
        chk("post_reset_lo", 64'(lo), 64'd6);
        chk("post_reset_hi", 64'(hi), 64'd0);
        idle(1);

        // Randomized traffic: starts, writes and operands at any time
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(7) == 0, 2'($urandom_range(3)), pick(), pick(),
                $urandom_range(3) == 0, $urandom_range(3) == 0, $urandom);
        idle(35);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
